pipo_univ: RTL and testbench

Parametrised universal datapath register, successor to the fixed 16-bit load/clear register used throughout the datapath. Adds shift, rotate, increment and decrement modes, a serial in/out path, and a registered carry/borrow flag. Operand, counter and shift-accumulator registers in the GCD/multiplier datapaths can use it directly, driven by the controller's `ld`/`en`/`mode` lines.

---
 rtl/pipo_univ_pkg.sv | 15 +
 rtl/pipo_univ_alu.sv | 104 ++++++++++
 rtl/pipo_univ.sv | 88 ++++++++
 tb/tb_pipo_univ.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipo_univ_pkg.sv
// Shared mode encoding for the universal datapath register and its controller.
package pipo_univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_SHL  = 3'd1,
    MODE_SHR  = 3'd2,
    MODE_ASR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INC  = 3'd6,
    MODE_DEC  = 3'd7
  } mode_e;

endpackage

// File: rtl/pipo_univ_alu.sv
// Combinational next-state logic for pipo_univ: shift/rotate/inc/dec results plus update flags.
// Define PIPO_UNIV_SAT_EN to make INC/DEC saturate instead of wrapping.
module pipo_univ_alu
  import pipo_univ_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] dout_i,
  input  mode_e            mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] data_nxt_o,
  output logic             sout_nxt_o,
  output logic             cout_nxt_o,
  output logic             data_upd_o,
  output logic             sout_upd_o,
  output logic             cout_upd_o
);

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] inc_ext_s;
  logic [WIDTH:0] dec_ext_s;

  // Carry/borrow live in bit WIDTH of the extended sum/difference.
  assign inc_ext_s = {1'b0, dout_i} + ONE_EXT;
  assign dec_ext_s = {1'b0, dout_i} - ONE_EXT;

  // Mode decode: select next data and which of data/sout/cout this mode updates.
  always_comb begin
    data_nxt_o = dout_i;
    sout_nxt_o = 1'b0;
    cout_nxt_o = 1'b0;
    data_upd_o = 1'b0;
    sout_upd_o = 1'b0;
    cout_upd_o = 1'b0;
    case (mode_i)
      MODE_HOLD: begin
        data_upd_o = 1'b0;
      end
      MODE_SHL: begin
        data_nxt_o = {dout_i[WIDTH-2:0], sin_i};
        sout_nxt_o = dout_i[WIDTH-1];
        data_upd_o = 1'b1;
        sout_upd_o = 1'b1;
      end
      MODE_SHR: begin
        data_nxt_o = {sin_i, dout_i[WIDTH-1:1]};
        sout_nxt_o = dout_i[0];
        data_upd_o = 1'b1;
        sout_upd_o = 1'b1;
      end
      MODE_ASR: begin
        data_nxt_o = {dout_i[WIDTH-1], dout_i[WIDTH-1:1]};
        sout_nxt_o = dout_i[0];
        data_upd_o = 1'b1;
        sout_upd_o = 1'b1;
      end
      MODE_ROL: begin
        data_nxt_o = {dout_i[WIDTH-2:0], dout_i[WIDTH-1]};
        sout_nxt_o = dout_i[WIDTH-1];
        data_upd_o = 1'b1;
        sout_upd_o = 1'b1;
      end
      MODE_ROR: begin
        data_nxt_o = {dout_i[0], dout_i[WIDTH-1:1]};
        sout_nxt_o = dout_i[0];
        data_upd_o = 1'b1;
        sout_upd_o = 1'b1;
      end
      MODE_INC: begin
        cout_nxt_o = inc_ext_s[WIDTH];
        data_upd_o = 1'b1;
        cout_upd_o = 1'b1;
`ifdef PIPO_UNIV_SAT_EN
        if (inc_ext_s[WIDTH]) begin
          data_nxt_o = dout_i;
        end else begin
          data_nxt_o = inc_ext_s[WIDTH-1:0];
        end
`else
        data_nxt_o = inc_ext_s[WIDTH-1:0];
`endif
      end
      MODE_DEC: begin
        cout_nxt_o = dec_ext_s[WIDTH];
        data_upd_o = 1'b1;
        cout_upd_o = 1'b1;
`ifdef PIPO_UNIV_SAT_EN
        if (dec_ext_s[WIDTH]) begin
          data_nxt_o = dout_i;
        end else begin
          data_nxt_o = dec_ext_s[WIDTH-1:0];
        end
`else
        data_nxt_o = dec_ext_s[WIDTH-1:0];
`endif
      end
      default: begin
        data_upd_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipo_univ.sv
// Universal datapath register: clear > load > mode operation > hold, with registered sout/cout.
// Optional saturating INC/DEC via PIPO_UNIV_SAT_EN (handled in pipo_univ_alu).
module pipo_univ
  import pipo_univ_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             sout_o,
  output logic             cout_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sout_q, sout_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] alu_data_s;
  logic             alu_sout_s, alu_cout_s;
  logic             alu_data_upd_s, alu_sout_upd_s, alu_cout_upd_s;

  pipo_univ_alu #(.WIDTH(WIDTH)) u_alu (
    .dout_i     (dout_q),
    .mode_i     (mode_e'(mode_i)),
    .sin_i      (sin_i),
    .data_nxt_o (alu_data_s),
    .sout_nxt_o (alu_sout_s),
    .cout_nxt_o (alu_cout_s),
    .data_upd_o (alu_data_upd_s),
    .sout_upd_o (alu_sout_upd_s),
    .cout_upd_o (alu_cout_upd_s)
  );

  // Load/operate/hold selection; clear is applied in the register process.
  always_comb begin
    dout_d = dout_q;
    sout_d = sout_q;
    cout_d = cout_q;
    if (ld_i) begin
      dout_d = din_i;
    end else if (en_i) begin
      if (alu_data_upd_s) begin
        dout_d = alu_data_s;
      end else begin
        dout_d = dout_q;
      end
      if (alu_sout_upd_s) begin
        sout_d = alu_sout_s;
      end else begin
        sout_d = sout_q;
      end
      if (alu_cout_upd_s) begin
        cout_d = alu_cout_s;
      end else begin
        cout_d = cout_q;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      dout_q <= RST_VAL;
      sout_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      sout_q <= sout_d;
      cout_q <= cout_d;
    end
  end

  assign dout_o = dout_q;
  assign sout_o = sout_q;
  assign cout_o = cout_q;
  assign zero_o = (dout_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_pipo_univ.sv
// Directed table-driven bench for pipo_univ (16-bit, RST_VAL=0); tracks the PIPO_UNIV_SAT_EN build too.
module tb_pipo_univ;
  import pipo_univ_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         clr, ld, en, sin;
  logic [2:0]   mode;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         sout, cout, zero;

  int total = 0;
  int bad   = 0;

  pipo_univ #(.WIDTH(W), .RST_VAL(16'h0000)) dut (
    .clk_i  (clk),
    .clr_i  (clr),
    .ld_i   (ld),
    .en_i   (en),
    .mode_i (mode),
    .din_i  (din),
    .sin_i  (sin),
    .dout_o (dout),
    .sout_o (sout),
    .cout_o (cout),
    .zero_o (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr, ld, en, sin;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] e_dout;
    logic         e_sout, e_cout, e_zero;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

`ifdef PIPO_UNIV_SAT_EN
  localparam logic [W-1:0] INC_FFFF = 16'hFFFF;
  localparam logic [W-1:0] DEC_0_A  = 16'h0000;
  localparam logic [W-1:0] DEC_0_B  = 16'h0000;
  localparam logic         C_DEC_B  = 1'b1;
`else
  localparam logic [W-1:0] INC_FFFF = 16'h0000;
  localparam logic [W-1:0] DEC_0_A  = 16'hFFFF;
  localparam logic [W-1:0] DEC_0_B  = 16'hFFFE;
  localparam logic         C_DEC_B  = 1'b0;
`endif

  function automatic vec_t mk(input logic c, input logic l, input logic e, input logic [2:0] m,
                              input logic [W-1:0] d, input logic s, input logic [W-1:0] ed,
                              input logic es, input logic ec);
    vec_t v;
    v.clr = c; v.ld = l; v.en = e; v.mode = m; v.din = d; v.sin = s;
    v.e_dout = ed; v.e_sout = es; v.e_cout = ec; v.e_zero = (ed == 16'h0000);
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic c, input logic l, input logic e, input logic [2:0] m,
                       input logic [W-1:0] d, input logic s);
    clr = c; ld = l; en = e; mode = m; din = d; sin = s;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] rot_exp;

  initial begin
    clr = 1'b0; ld = 1'b0; en = 1'b0; mode = 3'd0; din = 16'h0000; sin = 1'b0;

    vt[0]  = mk(1'b1, 1'b1, 1'b0, MODE_HOLD, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0);
    vt[1]  = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0);
    vt[2]  = mk(1'b0, 1'b0, 1'b1, MODE_SHL,  16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0);
    vt[3]  = mk(1'b0, 1'b0, 1'b1, MODE_SHL,  16'h0000, 1'b1, 16'h0007, 1'b0, 1'b0);
    vt[4]  = mk(1'b0, 1'b0, 1'b1, MODE_SHL,  16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0);
    vt[5]  = mk(1'b0, 1'b0, 1'b1, MODE_SHL,  16'h0000, 1'b1, 16'h001F, 1'b0, 1'b0);
    vt[6]  = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
    vt[7]  = mk(1'b0, 1'b0, 1'b1, MODE_ROR,  16'h0000, 1'b0, 16'h8000, 1'b1, 1'b0);
    vt[8]  = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0);
    vt[9]  = mk(1'b0, 1'b0, 1'b1, MODE_ASR,  16'h0000, 1'b1, 16'hC000, 1'b0, 1'b0);
    vt[10] = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    vt[11] = mk(1'b0, 1'b0, 1'b1, MODE_INC,  16'h0000, 1'b0, INC_FFFF, 1'b0, 1'b1);
    vt[12] = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    vt[13] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  16'h0000, 1'b0, DEC_0_A,  1'b0, 1'b1);
    vt[14] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  16'h0000, 1'b0, DEC_0_B,  1'b0, C_DEC_B);
    vt[15] = mk(1'b0, 1'b1, 1'b1, MODE_INC,  16'h1234, 1'b0, 16'h1234, 1'b0, C_DEC_B);
    vt[16] = mk(1'b0, 1'b0, 1'b1, MODE_HOLD, 16'h0000, 1'b1, 16'h1234, 1'b0, C_DEC_B);
    vt[17] = mk(1'b0, 1'b0, 1'b0, MODE_INC,  16'h0000, 1'b1, 16'h1234, 1'b0, C_DEC_B);
    vt[18] = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h00F0, 1'b0, 16'h00F0, 1'b0, C_DEC_B);
    vt[19] = mk(1'b0, 1'b0, 1'b1, MODE_SHR,  16'h0000, 1'b0, 16'h0078, 1'b0, C_DEC_B);
    vt[20] = mk(1'b0, 1'b0, 1'b1, MODE_SHR,  16'h0000, 1'b1, 16'h803C, 1'b0, C_DEC_B);
    vt[21] = mk(1'b1, 1'b0, 1'b1, MODE_SHR,  16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    vt[22] = mk(1'b0, 1'b0, 1'b0, MODE_SHR,  16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    vt[23] = mk(1'b0, 1'b0, 1'b0, MODE_SHR,  16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
    vt[24] = mk(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h8001, 1'b0, 16'h8001, 1'b0, 1'b0);
    vt[25] = mk(1'b0, 1'b0, 1'b1, MODE_ROL,  16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0);
    vt[26] = mk(1'b0, 1'b0, 1'b1, MODE_INC,  16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0);
    vt[27] = mk(1'b0, 1'b0, 1'b1, MODE_DEC,  16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      apply(vt[i].clr, vt[i].ld, vt[i].en, vt[i].mode, vt[i].din, vt[i].sin);
      chk($sformatf("v%0d.dout", i), dout, vt[i].e_dout);
      chk($sformatf("v%0d.sout", i), {15'd0, sout}, {15'd0, vt[i].e_sout});
      chk($sformatf("v%0d.cout", i), {15'd0, cout}, {15'd0, vt[i].e_cout});
      chk($sformatf("v%0d.zero", i), {15'd0, zero}, {15'd0, vt[i].e_zero});
    end

    // Rotate left a full WIDTH turns: the original pattern must come back.
    apply(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'hA5C3, 1'b0);
    rot_exp = 16'hA5C3;
    for (int k = 0; k < W; k++) begin
      apply(1'b0, 1'b0, 1'b1, MODE_ROL, 16'h0000, 1'b0);
      rot_exp = {rot_exp[W-2:0], rot_exp[W-1]};
      chk($sformatf("rol%0d.dout", k), dout, rot_exp);
      chk($sformatf("rol%0d.sout", k), {15'd0, sout}, {15'd0, rot_exp[0]});
    end
    chk("rol.full_turn", dout, 16'hA5C3);

    // Clear in the middle of an SHL train, then the train resumes from RST_VAL.
    apply(1'b0, 1'b1, 1'b0, MODE_HOLD, 16'h00FF, 1'b0);
    apply(1'b0, 1'b0, 1'b1, MODE_SHL, 16'h0000, 1'b1);
    chk("shl_pre.dout", dout, 16'h01FF);
    apply(1'b1, 1'b1, 1'b1, MODE_SHL, 16'hFFFF, 1'b1);
    chk("shl_clr.dout", dout, 16'h0000);
    chk("shl_clr.zero", {15'd0, zero}, 16'h0001);
    apply(1'b0, 1'b0, 1'b1, MODE_SHL, 16'h0000, 1'b1);
    chk("shl_post.dout", dout, 16'h0001);
    chk("shl_post.sout", {15'd0, sout}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
